// File: rtl/stack_seq_pkg.sv
// ============================================================================
// stack_seq_pkg: shared opcodes, token kinds, state type and depth sizing.
// Rev 1.0
// ============================================================================
`default_nettype none

package stack_seq_pkg;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;
  localparam logic [2:0] OP_PUSH = 3'b110;
  localparam logic [2:0] OP_POP  = 3'b111;

  localparam logic [1:0] TOK_OPND = 2'b00;
  localparam logic [1:0] TOK_ADD  = 2'b01;
  localparam logic [1:0] TOK_MUL  = 2'b10;
  localparam logic [1:0] TOK_END  = 2'b11;

  typedef enum logic [2:0] {
    ST_ACCEPT  = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_SKIP    = 3'd3,
    ST_DRAIN   = 3'd4,
    ST_POPWAIT = 3'd5,
    ST_DONE    = 3'd6
  } state_t;

  // Wide enough to hold the value DEPTH itself (the "full" count).
  function automatic int depth_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/stack_seq_depth_ctr.sv
// ============================================================================
// stack_seq_depth_ctr: mirror of the ALU stack occupancy with decode flags.
// Rev 1.0
// ============================================================================
`default_nettype none

module stack_seq_depth_ctr
  import stack_seq_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int DW    = depth_width(DEPTH)
) (
  input  logic CLK,
  input  logic RST,
  input  logic inc,
  input  logic dec,
  input  logic clear,
  output logic empty,
  output logic one,
  output logic ge2,
  output logic full
);

  localparam logic [DW-1:0] c_one  = DW'(1);
  localparam logic [DW-1:0] c_two  = DW'(2);
  localparam logic [DW-1:0] c_full = DW'(DEPTH);

  logic [DW-1:0] r_depth;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_depth <= '0;
    end else if (clear) begin
      r_depth <= '0;
    end else if (inc && !dec && !full) begin
      r_depth <= r_depth + c_one;
    end else if (dec && !inc && !empty) begin
      r_depth <= r_depth - c_one;
    end
  end

  assign empty = (r_depth == '0);
  assign one   = (r_depth == c_one);
  assign ge2   = (r_depth >= c_two);
  assign full  = (r_depth == c_full);

endmodule

`default_nettype wire

// File: rtl/stack_alu_rpn_sequencer.sv
// ============================================================================
// stack_alu_rpn_sequencer: drives a stack ALU through one RPN expression.
// Rev 1.0. Define STACK_SEQ_OVF_ABORT_EN to abort an expression on overflow.
// ============================================================================
`default_nettype none

module stack_alu_rpn_sequencer
  import stack_seq_pkg::*;
#(
  parameter int N     = 4,
  parameter int DEPTH = 8
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         tok_valid,
  output logic         tok_ready,
  input  logic [1:0]   tok_kind,
  input  logic [N-1:0] tok_data,
  output logic [2:0]   alu_opcode,
  output logic [N-1:0] alu_data,
  input  logic [N-1:0] alu_result,
  input  logic         alu_overflow,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [N-1:0] res_data,
  output logic         res_overflow,
  output logic         res_error
);

  state_t r_state;

  logic w_tok_fire;
  logic w_is_arith;
  logic w_inc;
  logic w_dec;
  logic w_clear;
  logic w_empty;
  logic w_one;
  logic w_ge2;
  logic w_full;
  logic w_abort;

  assign w_tok_fire = tok_valid & tok_ready;
  assign w_is_arith = (tok_kind == TOK_ADD) | (tok_kind == TOK_MUL);
  assign w_inc      = (r_state == ST_ACCEPT) & w_tok_fire & (tok_kind == TOK_OPND) & ~w_full;
  assign w_dec      = ((r_state == ST_ACCEPT) & w_tok_fire & w_is_arith & w_ge2)
                    | (r_state == ST_DRAIN);
  assign w_clear    = (r_state == ST_DONE) & res_valid & res_ready;

`ifdef STACK_SEQ_OVF_ABORT_EN
  assign w_abort = alu_overflow;
`else
  assign w_abort = 1'b0;
`endif

  stack_seq_depth_ctr #(
    .DEPTH (DEPTH)
  ) u_depth_ctr (
    .CLK   (CLK),
    .RST   (RST),
    .inc   (w_inc),
    .dec   (w_dec),
    .clear (w_clear),
    .empty (w_empty),
    .one   (w_one),
    .ge2   (w_ge2),
    .full  (w_full)
  );

  // tok_ready is registered, so it rises one cycle after reset release.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state      <= ST_ACCEPT;
      tok_ready    <= 1'b0;
      alu_opcode   <= OP_NOP;
      alu_data     <= '0;
      res_valid    <= 1'b0;
      res_data     <= '0;
      res_overflow <= 1'b0;
      res_error    <= 1'b0;
    end else begin
      alu_opcode <= OP_NOP;
      unique case (r_state)
        ST_ACCEPT: begin
          tok_ready <= 1'b1;
          if (w_tok_fire) begin
            unique case (tok_kind)
              TOK_OPND: begin
                if (w_full) begin
                  res_error <= 1'b1;
                  r_state   <= ST_SKIP;
                end else begin
                  alu_opcode <= OP_PUSH;
                  alu_data   <= tok_data;
                  tok_ready  <= 1'b0;
                  r_state    <= ST_ISSUE;
                end
              end
              TOK_ADD, TOK_MUL: begin
                if (!w_ge2) begin
                  res_error <= 1'b1;
                  r_state   <= ST_SKIP;
                end else begin
                  alu_opcode <= (tok_kind == TOK_ADD) ? OP_ADD : OP_MUL;
                  tok_ready  <= 1'b0;
                  r_state    <= ST_ISSUE;
                end
              end
              default: begin
                tok_ready <= 1'b0;
                if (w_empty) begin
                  res_error <= 1'b1;
                  res_valid <= 1'b1;
                  r_state   <= ST_DONE;
                end else begin
                  if (!w_one) res_error <= 1'b1;
                  alu_opcode <= OP_POP;
                  r_state    <= ST_DRAIN;
                end
              end
            endcase
          end
        end
        ST_ISSUE: begin
          if (alu_opcode == OP_PUSH) begin
            tok_ready <= 1'b1;
            r_state   <= ST_ACCEPT;
          end else begin
            r_state <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          res_overflow <= res_overflow | alu_overflow;
          tok_ready    <= 1'b1;
          if (w_abort) begin
            res_error <= 1'b1;
            r_state   <= ST_SKIP;
          end else begin
            r_state <= ST_ACCEPT;
          end
        end
        ST_SKIP: begin
          if (w_tok_fire && (tok_kind == TOK_END)) begin
            tok_ready <= 1'b0;
            if (w_empty) begin
              res_valid <= 1'b1;
              r_state   <= ST_DONE;
            end else begin
              alu_opcode <= OP_POP;
              r_state    <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          r_state <= ST_POPWAIT;
        end
        ST_POPWAIT: begin
          // Depth has already been decremented, so empty marks the last pop.
          if (w_empty) begin
            if (!res_error) res_data <= alu_result;
            res_valid <= 1'b1;
            r_state   <= ST_DONE;
          end else begin
            alu_opcode <= OP_POP;
            r_state    <= ST_DRAIN;
          end
        end
        ST_DONE: begin
          if (res_ready) begin
            res_valid    <= 1'b0;
            res_data     <= '0;
            res_overflow <= 1'b0;
            res_error    <= 1'b0;
            tok_ready    <= 1'b1;
            r_state      <= ST_ACCEPT;
          end
        end
        default: begin
          r_state <= ST_ACCEPT;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_stack_alu_rpn_sequencer.sv
// ============================================================================
// tb_stack_alu_rpn_sequencer: table-driven and randomized checks of the
// sequencer against a stack ALU model and a queue-based RPN reference. Rev 1.0
// ============================================================================
`default_nettype none

module tb_stack_alu_rpn_sequencer;
  import stack_seq_pkg::*;

  localparam int N     = 4;
  localparam int DEPTH = 8;
`ifdef STACK_SEQ_OVF_ABORT_EN
  localparam bit ABT = 1'b1;
`else
  localparam bit ABT = 1'b0;
`endif

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         tok_valid = 1'b0;
  logic         tok_ready;
  logic [1:0]   tok_kind = 2'b00;
  logic [N-1:0] tok_data = '0;
  logic [2:0]   alu_opcode;
  logic [N-1:0] alu_data;
  logic [N-1:0] alu_result = '0;
  logic         alu_overflow = 1'b0;
  logic         res_valid;
  logic         res_ready = 1'b0;
  logic [N-1:0] res_data;
  logic         res_overflow;
  logic         res_error;

  always #5 CLK = ~CLK;

  stack_alu_rpn_sequencer #(.N(N), .DEPTH(DEPTH)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .tok_valid    (tok_valid),
    .tok_ready    (tok_ready),
    .tok_kind     (tok_kind),
    .tok_data     (tok_data),
    .alu_opcode   (alu_opcode),
    .alu_data     (alu_data),
    .alu_result   (alu_result),
    .alu_overflow (alu_overflow),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_data     (res_data),
    .res_overflow (res_overflow),
    .res_error    (res_error)
  );

  // Stack ALU environment model plus per-opcode issue counters.
  logic [N-1:0] alu_stk [64];
  int  alu_sp = 0;
  logic alu_flush = 1'b0;
  int  n_push = 0, n_pop = 0, n_arith = 0;

  always @(posedge CLK) begin : alu_model
    int a, b, r;
    if (alu_flush) begin
      alu_sp <= 0;
    end else begin
      case (alu_opcode)
        OP_PUSH: begin
          alu_stk[alu_sp[5:0]] <= alu_data;
          alu_sp <= alu_sp + 1;
          n_push <= n_push + 1;
        end
        OP_ADD, OP_MUL: begin
          n_arith <= n_arith + 1;
          if (alu_sp >= 2) begin
            a = int'($signed(alu_stk[6'(alu_sp - 2)]));
            b = int'($signed(alu_stk[6'(alu_sp - 1)]));
            r = (alu_opcode == OP_ADD) ? a + b : a * b;
            alu_stk[6'(alu_sp - 2)] <= r[N-1:0];
            alu_result   <= r[N-1:0];
            alu_overflow <= (r > 7) || (r < -8);
            alu_sp <= alu_sp - 1;
          end
        end
        OP_POP: begin
          n_pop <= n_pop + 1;
          if (alu_sp >= 1) begin
            alu_result <= alu_stk[6'(alu_sp - 1)];
            alu_sp <= alu_sp - 1;
          end
        end
        default: ;
      endcase
    end
  end

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Expression text: 0-9/a-f operand (hex, two's complement), + add, * mul, . END
  function automatic void decode(input byte c, output logic [1:0] k, output logic [N-1:0] v);
    k = TOK_OPND;
    v = '0;
    if (c == "+")      k = TOK_ADD;
    else if (c == "*") k = TOK_MUL;
    else if (c == ".") k = TOK_END;
    else if (c >= "a") v = N'(c - 8'h61 + 8'd10);
    else               v = N'(c - 8'h30);
  endfunction

  function automatic void ref_model(input string ex, output logic [N-1:0] d, output logic ovf,
                                    output logic err, output int np, output int na, output int npop);
    int q[$];
    int a, b, r, t;
    logic [1:0] k;
    logic [N-1:0] v;
    d = '0; ovf = 1'b0; err = 1'b0; np = 0; na = 0;
    for (int i = 0; i < ex.len(); i++) begin
      decode(ex[i], k, v);
      if (k == TOK_END) begin
        if (q.size() != 1) err = 1'b1;
        break;
      end else if (k == TOK_OPND) begin
        if (q.size() == DEPTH) begin err = 1'b1; break; end
        q.push_back(int'($signed(v)));
        np++;
      end else begin
        if (q.size() < 2) begin err = 1'b1; break; end
        b = q.pop_back();
        a = q.pop_back();
        r = (k == TOK_ADD) ? a + b : a * b;
        na++;
        t = ((r % 16) + 16) % 16;
        if (t > 7) t -= 16;
        q.push_back(t);
        if (r != t) begin
          ovf = 1'b1;
          if (ABT) begin err = 1'b1; break; end
        end
      end
    end
    npop = q.size();
    if (!err) begin
      t = q[0];
      d = t[N-1:0];
    end
  endfunction

  task automatic run_expr(input string ex, input logic [N-1:0] e_data, input logic e_ovf,
                          input logic e_err, input int e_push, input int e_arith,
                          input int e_pop, input int hold);
    int p0, a0, q0, w;
    logic [1:0] k;
    logic [N-1:0] v;
    p0 = n_push; a0 = n_arith; q0 = n_pop;
    for (int i = 0; i < ex.len(); i++) begin
      @(negedge CLK);
      if ($urandom_range(0, 3) == 0) begin
        tok_valid = 1'b0;
        @(negedge CLK);
      end
      decode(ex[i], k, v);
      tok_valid = 1'b1;
      tok_kind  = k;
      tok_data  = v;
      w = 0;
      while (!tok_ready && w < 64) begin @(negedge CLK); w++; end
      if (!tok_ready) begin
        check($sformatf("tok_ready_timeout[%s]", ex), 0, 1);
        tok_valid = 1'b0;
        return;
      end
      @(posedge CLK);
    end
    @(negedge CLK);
    tok_valid = 1'b0;
    w = 0;
    while (!res_valid && w < 64) begin @(negedge CLK); w++; end
    check($sformatf("res_valid[%s]", ex), int'(res_valid), 1);
    if (!res_valid) return;
    check($sformatf("res_data[%s]", ex), int'(res_data), int'(e_data));
    check($sformatf("res_overflow[%s]", ex), int'(res_overflow), int'(e_ovf));
    check($sformatf("res_error[%s]", ex), int'(res_error), int'(e_err));
    check($sformatf("tok_ready_in_done[%s]", ex), int'(tok_ready), 0);
    for (int h = 0; h < hold; h++) begin
      @(negedge CLK);
      check($sformatf("hold_valid%0d[%s]", h, ex), int'(res_valid), 1);
      check($sformatf("hold_data%0d[%s]", h, ex), int'(res_data), int'(e_data));
      check($sformatf("hold_tok_ready%0d[%s]", h, ex), int'(tok_ready), 0);
    end
    res_ready = 1'b1;
    @(negedge CLK);
    res_ready = 1'b0;
    check($sformatf("valid_cleared[%s]", ex), int'(res_valid), 0);
    check($sformatf("flags_cleared[%s]", ex), int'({res_data, res_overflow, res_error}), 0);
    check($sformatf("back_to_accept[%s]", ex), int'(tok_ready), 1);
    check($sformatf("pushes[%s]", ex), n_push - p0, e_push);
    check($sformatf("ariths[%s]", ex), n_arith - a0, e_arith);
    check($sformatf("pops[%s]", ex), n_pop - q0, e_pop);
    check($sformatf("alu_balanced[%s]", ex), alu_sp, 0);
  endtask

  typedef struct {
    string        ex;
    logic [N-1:0] data;
    logic         ovf;
    logic         err;
    int           np;
    int           na;
    int           npop;
  } vec_t;

  vec_t tbl[11];

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    string hexs;
    string s;
    logic [N-1:0] m_d;
    logic m_o, m_e;
    int m_np, m_na, m_pop, d, r, len;

    tbl[0]  = '{"23+.",       4'd5,                 1'b0, 1'b0, 2, 1, 1};
    tbl[1]  = '{"32*1+.",     4'd7,                 1'b0, 1'b0, 3, 2, 1};
    tbl[2]  = '{"71+.",       ABT ? 4'd0 : 4'd8,    1'b1, ABT,  2, 1, 1};
    tbl[3]  = '{"+5.",        4'd0,                 1'b0, 1'b1, 0, 0, 0};
    tbl[4]  = '{"12.",        4'd0,                 1'b0, 1'b1, 2, 0, 2};
    tbl[5]  = '{"123456789.", 4'd0,                 1'b0, 1'b1, 8, 0, 8};
    tbl[6]  = '{".",          4'd0,                 1'b0, 1'b1, 0, 0, 0};
    tbl[7]  = '{"35*.",       ABT ? 4'd0 : 4'd15,   1'b1, ABT,  2, 1, 1};
    tbl[8]  = '{"ed*.",       4'd6,                 1'b0, 1'b0, 2, 1, 1};
    tbl[9]  = '{"5+.",        4'd0,                 1'b0, 1'b1, 1, 0, 1};
    tbl[10] = '{"73+4+.",     ABT ? 4'd0 : 4'd14,   1'b1, ABT,  ABT ? 2 : 3, ABT ? 1 : 2, 1};

    alu_flush = 1'b1;
    repeat (2) @(negedge CLK);
    check("reset_outputs", int'({tok_ready, alu_opcode, alu_data, res_valid,
                                 res_data, res_overflow, res_error}), 0);
    RST = 1'b0;
    alu_flush = 1'b0;
    @(negedge CLK);
    check("ready_after_reset", int'(tok_ready), 1);

    for (int i = 0; i < 11; i++)
      run_expr(tbl[i].ex, tbl[i].data, tbl[i].ovf, tbl[i].err,
               tbl[i].np, tbl[i].na, tbl[i].npop, (i == 0) ? 3 : 0);

    // Reset while the first push is being issued.
    @(negedge CLK);
    tok_valid = 1'b1;
    tok_kind  = TOK_OPND;
    tok_data  = 4'd3;
    @(posedge CLK);
    @(negedge CLK);
    tok_valid = 1'b0;
    check("issue_push_visible", int'(alu_opcode), int'(OP_PUSH));
    RST = 1'b1;
    alu_flush = 1'b1;
    @(posedge CLK);
    #1;
    check("rst_in_issue_outputs", int'({tok_ready, alu_opcode, alu_data, res_valid,
                                        res_data, res_overflow, res_error}), 0);
    @(negedge CLK);
    RST = 1'b0;
    alu_flush = 1'b0;
    @(negedge CLK);
    check("accept_after_mid_rst", int'(tok_ready), 1);
    run_expr("23+.", 4'd5, 1'b0, 1'b0, 2, 1, 1, 0);

    // Randomized expressions scored against the queue-based reference.
    hexs = "0123456789abcdef";
    for (int n = 0; n < 40; n++) begin
      s = "";
      d = 0;
      len = ($urandom_range(0, 9) == 0) ? 11 : $urandom_range(1, 9);
      for (int t = 0; t < len; t++) begin
        r = $urandom_range(0, 9);
        if (d < 2 && r >= 6 && $urandom_range(0, 3) != 0) r = 0;
        if (r < 6) begin
          s = $sformatf("%s%c", s, hexs[$urandom_range(0, 15)]);
          d++;
        end else begin
          s = $sformatf("%s%c", s, (r < 8) ? "+" : "*");
          if (d >= 2) d--;
        end
      end
      s = {s, "."};
      ref_model(s, m_d, m_o, m_e, m_np, m_na, m_pop);
      run_expr(s, m_d, m_o, m_e, m_np, m_na, m_pop, $urandom_range(0, 2));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
